matmul_stream_tx: RTL
=====================

# matmul_stream_tx

Transmitter for the systolic matrix-multiply load protocol. It buffers an N×5 weight matrix and a T-column input matrix written through a simple register port. On START it replays both on the `Weight` and `In` buses in the order the MatMul core expects: nonzero data words, each group terminated by one all-zero delimiter word. After the last delimiter it holds the buses idle for a fixed drain window, then signals completion. It sits between the host/testbench write side and the MatMul core's `Weight_i`/`In_i` inputs.

## Interface
- `N`, default 5: number of weight rows sent.
- `T`, default 10: number of input columns sent.
- `DW`, default 40: bus width, five 8-bit lanes with lane 0 at [DW-1:DW-8].
- `DRAIN`, default T+24: idle cycles held after the input delimiter.
- `CLK` input 1: clock.
- `RST` input 1: reset. One clock; reset is synchronous and active-high.
- `WR_EN_i` input 1: write strobe.
- `WR_SEL_i` input 1: 0 = weight buffer, 1 = input buffer.
- `WR_ADDR_i` input 4: row/column index.
- `WR_DATA_i` input DW: word to store.
- `START_i` input 1: begin transmission, sampled in IDLE only.
- `BUSY_o` output 1: transmission or drain in progress.
- `DONE_o` output 1: one-cycle pulse at end of drain.
- `ERR_o` output 1: one-cycle pulse when a START is rejected.
- `Weight_o` output DW: to MatMul `Weight_i`.
- `In_o` output DW: to MatMul `In_i`.

## Operation
- Storage:
  - `wbuf[0:N-1]`, `ibuf[0:T-1]`.
  - Per-entry valid flags `wv[N]`, `iv[T]`; a flag is set iff the last accepted write to that entry was nonzero.
- Write acceptance: a write is accepted only when all of these hold: state IDLE, `WR_EN_i`=1, `START_i`=0, and `WR_ADDR_i` < N (SEL=0) or < T (SEL=1). All other writes are silently dropped.
- START in IDLE:
  - Accepted iff all of `wv` and all of `iv` are set, because a zero data word would be read by the core as a premature delimiter.
  - Rejected otherwise: `ERR_o` pulses and the state stays IDLE.
- States, one-hot:
  - IDLE: both buses 0.
  - SEND_W: `Weight_o`=`wbuf[k]`, `In_o`=0; k counts 0..N-1.
  - DELIM_W: 1 cycle, both buses 0.
  - SEND_I: `In_o`=`ibuf[k]`, `Weight_o`=0; k counts 0..T-1.
  - DELIM_I: 1 cycle, both buses 0.
  - DRAIN: DRAIN cycles, both buses 0.
  - Then back to IDLE.
- Transitions: IDLE→SEND_W on accepted START; SEND_W→DELIM_W when k=N-1; DELIM_W→SEND_I; SEND_I→DELIM_I when k=T-1; DELIM_I→DRAIN; DRAIN→IDLE when the drain counter reaches DRAIN-1.
- START, WR_EN and reads while not in IDLE are ignored. Buffer contents and flags persist, so repeated STARTs resend the same data.
- Words pass through unmodified; no lane reordering, no arithmetic.
- All outputs are registered.

## Timing
- Reset: next edge sets state IDLE, `BUSY_o`=0, `DONE_o`=0, `ERR_o`=0, `Weight_o`=0, `In_o`=0, and clears all `wv`/`iv` flags. Buffer data is left unchanged.
- Reset mid-transmission: the buses are 0 from the following cycle, with no DONE pulse.
- START accepted at edge c:
  - Weight row k is visible in cycle c+1+k.
  - Weight delimiter: cycle c+N+1.
  - Input column k: cycle c+N+2+k.
  - Input delimiter: cycle c+N+T+2.
  - Drain: cycles c+N+T+3 .. c+N+T+2+DRAIN.
  - `DONE_o`=1 in cycle c+N+T+3+DRAIN, with `BUSY_o` already 0.
- `BUSY_o` is 1 from cycle c+1 through the last drain cycle inclusive.
- Rejected START at edge c: `ERR_o`=1 in cycle c+1 only; `BUSY_o` stays 0.
- A START in the DONE cycle is accepted (the state is IDLE), so back-to-back runs are separated by exactly one idle cycle.
- A write at an edge updates its flag in time for a START at the next edge.

## Test plan
- Basic send (N=5, T=10): write `wbuf[i]`=0x0102030405+i and `ibuf[j]`=0x1111111111×(j+1), then START → `Weight_o` shows 5 rows in cycles c+1..c+5, 0 at c+6; `In_o` shows 10 columns in c+7..c+16, 0 at c+17; `DONE_o` at c+18+DRAIN (c+52).
- Missing entry: write all entries except `ibuf[7]`, then START → `ERR_o` pulse at c+1; `BUSY_o`=0; buses stay 0.
- Zero word: write `wbuf[2]`=0 after it was previously valid, then START → rejected with `ERR_o`. Rewrite 0x0000000001 → next START accepted and sends 0x0000000001.
- Ignored writes: during SEND_I issue a write with `WR_ADDR_i`=3, SEL=1, data 0xFF..FF; also write index 12 while in IDLE → both dropped; the second START resends the original `ibuf[3]`.
- Reset mid-SEND_W (at k=2) → buses 0 the next cycle; no `DONE_o`; a START immediately after reset is rejected with `ERR_o` because the flags are cleared.
- Back-to-back: assert START in the `DONE_o` cycle → the second transmission starts the next cycle with an identical waveform; verify against a MatMul core model that it sees exactly N weight rows and T input columns per run.

Source files
------------

// File: rtl/matmul_stream_tx_if.sv
// Host-side write port and MatMul-side load buses of matmul_stream_tx.
// Signal suffixes are from the transmitter's point of view.
interface matmul_stream_tx_if #(
  parameter int DW = 40
);
  logic          WR_EN_i;
  logic          WR_SEL_i;
  logic [3:0]    WR_ADDR_i;
  logic [DW-1:0] WR_DATA_i;
  logic          START_i;
  logic          BUSY_o;
  logic          DONE_o;
  logic          ERR_o;
  logic [DW-1:0] Weight_o;
  logic [DW-1:0] In_o;

  modport master (
    output WR_EN_i, WR_SEL_i, WR_ADDR_i, WR_DATA_i, START_i,
    input  BUSY_o, DONE_o, ERR_o, Weight_o, In_o
  );

  modport slave (
    input  WR_EN_i, WR_SEL_i, WR_ADDR_i, WR_DATA_i, START_i,
    output BUSY_o, DONE_o, ERR_o, Weight_o, In_o
  );
endinterface

// File: rtl/matmul_stream_tx.sv
// Buffers N weight rows and T input columns, then replays them on the
// Weight/In buses with zero delimiters followed by a fixed idle drain window.
module matmul_stream_tx #(
  parameter int N     = 5,
  parameter int T     = 10,
  parameter int DW    = 40,
  parameter int DRAIN = T + 24
) (
  input  logic                CLK,
  input  logic                RST,
  matmul_stream_tx_if.slave   bus
);

  localparam int MAXNT = (N > T) ? N : T;
  localparam int MAXC  = (MAXNT > DRAIN) ? MAXNT : DRAIN;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int AWN   = (N > 1) ? $clog2(N) : 1;
  localparam int AWT   = (T > 1) ? $clog2(T) : 1;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_SEND_W  = 6'b000010,
    S_DELIM_W = 6'b000100,
    S_SEND_I  = 6'b001000,
    S_DELIM_I = 6'b010000,
    S_DRAIN   = 6'b100000
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] wbuf_q [N];
  logic [DW-1:0] ibuf_q [T];
  logic [N-1:0]  wv_q;
  logic [T-1:0]  iv_q;

  logic [DW-1:0] weight_q, weight_d;
  logic [DW-1:0] in_q, in_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          all_valid;
  logic          wr_ok;
  logic          addr_in_range;

  assign all_valid     = (&wv_q) && (&iv_q);
  assign addr_in_range = bus.WR_SEL_i ? (32'(bus.WR_ADDR_i) < T)
                                      : (32'(bus.WR_ADDR_i) < N);
  assign wr_ok = (state_q == S_IDLE) && bus.WR_EN_i && !bus.START_i && addr_in_range;

  // Buffer data deliberately survives reset; only the valid flags are cleared.
  always_ff @(posedge CLK) begin
    if (!RST && wr_ok) begin
      if (bus.WR_SEL_i) ibuf_q[bus.WR_ADDR_i[AWT-1:0]] <= bus.WR_DATA_i;
      else              wbuf_q[bus.WR_ADDR_i[AWN-1:0]] <= bus.WR_DATA_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wv_q <= '0;
      iv_q <= '0;
    end else if (wr_ok) begin
      if (bus.WR_SEL_i) iv_q[bus.WR_ADDR_i[AWT-1:0]] <= |bus.WR_DATA_i;
      else              wv_q[bus.WR_ADDR_i[AWN-1:0]] <= |bus.WR_DATA_i;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      weight_q <= '0;
      in_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      in_q     <= in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_IDLE:    if (bus.START_i && all_valid) state_d = S_SEND_W;
      S_SEND_W:  if (cnt_q == CW'(N - 1)) state_d = S_DELIM_W;
                 else cnt_d = cnt_q + CW'(1);
      S_DELIM_W: state_d = S_SEND_I;
      S_SEND_I:  if (cnt_q == CW'(T - 1)) state_d = S_DELIM_I;
                 else cnt_d = cnt_q + CW'(1);
      S_DELIM_I: state_d = S_DRAIN;
      S_DRAIN:   if (cnt_q == CW'(DRAIN - 1)) state_d = S_IDLE;
                 else cnt_d = cnt_q + CW'(1);
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered buses line up
  // with the state they belong to.
  always_comb begin
    weight_d = '0;
    in_d     = '0;
    if (state_d == S_SEND_W) weight_d = wbuf_q[cnt_d[AWN-1:0]];
    if (state_d == S_SEND_I) in_d     = ibuf_q[cnt_d[AWT-1:0]];
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);
    err_d  = (state_q == S_IDLE) && bus.START_i && !all_valid;
  end

  assign bus.Weight_o = weight_q;
  assign bus.In_o     = in_q;
  assign bus.BUSY_o   = busy_q;
  assign bus.DONE_o   = done_q;
  assign bus.ERR_o    = err_q;

endmodule
